// File: rtl/bp_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bp_update_ctrl
// Description : Update and initialisation controller for the tournament
//               branch predictor tables (local PHT, global PHT, selector PHT).
//               Resolved branches are buffered in a small FIFO and serialised
//               into read-modify-write sequences on the shared table update
//               port. This block also owns the global history register.
//               After reset every table index is written with its initial
//               counter value before any update is serviced.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            in   rising-edge clock
//   rstn           in   asynchronous active-low reset
//   upd_valid      in   resolved branch presented by execute stage
//   upd_idx        in   local/selector index of the branch
//   upd_taken      in   resolved direction
//   upd_stall      out  FIFO full, push refused this cycle
//   init_busy      out  table initialisation in progress
//   ghist          out  global history register
//   tbl_en/tbl_we  out  update-port enable / write enable
//   tbl_addr_loc   out  local and selector table address
//   tbl_addr_glb   out  global table address
//   tbl_wdata_*    out  counter write data (loc, glb, sel)
//   tbl_rdata_*    in   counter read data, valid 1 cycle after read enable
// ============================================================================
module bp_update_ctrl #(
  parameter int         IDX_W      = 10,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_CNT   = 2'd1,
  parameter logic [1:0] INIT_SEL   = 2'd2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             upd_stall,
  output logic             init_busy,
  output logic [IDX_W-1:0] ghist,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_addr_loc,
  output logic [IDX_W-1:0] tbl_addr_glb,
  output logic [1:0]       tbl_wdata_loc,
  output logic [1:0]       tbl_wdata_glb,
  output logic [1:0]       tbl_wdata_sel,
  input  logic [1:0]       tbl_rdata_loc,
  input  logic [1:0]       tbl_rdata_glb,
  input  logic [1:0]       tbl_rdata_sel
);

  localparam int                c_PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [c_PTR_W:0]  c_FULL  = (c_PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_RD   = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_init_cnt;
  logic [IDX_W-1:0]   r_ghist;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_gaddr;
  logic               r_taken;

  logic [IDX_W-1:0]   r_fifo_idx [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_tkn;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;

  logic               w_push;
  logic               w_pop;
  logic [IDX_W-1:0]   w_head_idx;
  logic               w_lc;
  logic               w_gc;
  logic [1:0]         w_new_loc;
  logic [1:0]         w_new_glb;
  logic [1:0]         w_new_sel;

  function automatic logic [1:0] f_sat_step(input logic [1:0] v, input logic up);
    if (up) return (v == 2'd3) ? v : v + 2'd1;
    else    return (v == 2'd0) ? v : v - 2'd1;
  endfunction

  // Stall is a pure decode of the registered count; a same-cycle pop does
  // not free a slot for the incoming push.
  assign upd_stall  = (r_count == c_FULL);
  assign w_push     = upd_valid & ~upd_stall;
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_head_idx = r_fifo_idx[r_rd_ptr];
  assign ghist      = r_ghist;

  // Read data is sampled in WB, one cycle after the RD wait cycle.
  assign w_lc      = (tbl_rdata_loc[1] == r_taken);
  assign w_gc      = (tbl_rdata_glb[1] == r_taken);
  assign w_new_loc = f_sat_step(tbl_rdata_loc, r_taken);
  assign w_new_glb = f_sat_step(tbl_rdata_glb, r_taken);

  always_comb begin
    w_new_sel = tbl_rdata_sel;
    if (w_lc && !w_gc)      w_new_sel = f_sat_step(tbl_rdata_sel, 1'b0);
    else if (w_gc && !w_lc) w_new_sel = f_sat_step(tbl_rdata_sel, 1'b1);
  end

  // FIFO storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_idx[r_wr_ptr] <= upd_idx;
      r_fifo_tkn[r_wr_ptr] <= upd_taken;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
      r_ghist    <= '0;
      r_idx      <= '0;
      r_gaddr    <= '0;
      r_taken    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 1'b1;
      if (w_pop) begin
        r_idx   <= w_head_idx;
        r_taken <= r_fifo_tkn[r_rd_ptr];
        r_gaddr <= r_ghist;
      end
      if (r_state == S_WB) r_ghist <= {r_ghist[IDX_W-2:0], r_taken};
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    init_busy     = 1'b0;
    tbl_en        = 1'b0;
    tbl_we        = 1'b0;
    tbl_addr_loc  = '0;
    tbl_addr_glb  = '0;
    tbl_wdata_loc = 2'd0;
    tbl_wdata_glb = 2'd0;
    tbl_wdata_sel = 2'd0;
    unique case (r_state)
      S_INIT: begin
        init_busy     = 1'b1;
        tbl_en        = 1'b1;
        tbl_we        = 1'b1;
        tbl_addr_loc  = r_init_cnt;
        tbl_addr_glb  = r_init_cnt;
        tbl_wdata_loc = INIT_CNT;
        tbl_wdata_glb = INIT_CNT;
        tbl_wdata_sel = INIT_SEL;
        if (r_init_cnt == '1) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (w_pop) begin
          tbl_en       = 1'b1;
          tbl_addr_loc = w_head_idx;
          tbl_addr_glb = r_ghist;
          w_state_nxt  = S_RD;
        end
      end
      S_RD: begin
        w_state_nxt = S_WB;
      end
      S_WB: begin
        tbl_en        = 1'b1;
        tbl_we        = 1'b1;
        tbl_addr_loc  = r_idx;
        tbl_addr_glb  = r_gaddr;
        tbl_wdata_loc = w_new_loc;
        tbl_wdata_glb = w_new_glb;
        tbl_wdata_sel = w_new_sel;
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_INIT;
    endcase
    // State resets to INIT, which would otherwise drive init writes while
    // reset is still held; the port stays quiet until rstn is released.
    if (!rstn) begin
      tbl_en        = 1'b0;
      tbl_we        = 1'b0;
      tbl_addr_loc  = '0;
      tbl_addr_glb  = '0;
      tbl_wdata_loc = 2'd0;
      tbl_wdata_glb = 2'd0;
      tbl_wdata_sel = 2'd0;
    end
  end

endmodule
`default_nettype wire
